// File: rtl/spi_pkg.sv
// Shared definitions for the parametrised SPI slave.
//   SPI_MODE0..SPI_MODE3 : {CPOL, CPHA} encodings of the four SPI modes
//   spi_state_e          : slave framing state (wait / idle / active)
//   MIN_SCK_PHASE        : minimum sck high or low phase, in clk periods
package spi_pkg;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  localparam int MIN_SCK_PHASE = 4;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_slave_param_if.sv
// Fabric-side word exchange for spi_slave_param.
//   tx_data/tx_valid/tx_ready : transmit word handshake into the holding register
//   rx_data/rx_valid/rx_ready : received word handshake out of the receive buffer
//   rx_overrun/tx_underrun    : one-cycle status pulses
// Modports: slave (the SPI block), master (the fabric consumer/producer).
interface spi_slave_param_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic             rx_overrun;
  logic             tx_underrun;

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid, rx_overrun, tx_underrun
  );

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid, rx_overrun, tx_underrun
  );
endinterface

// File: rtl/spi_sync.sv
// Two-flop synchroniser bringing an asynchronous pin into the clk domain.
//   clk, rst_n : clock and synchronous active-low reset
//   d          : asynchronous input
//   q          : synchronised output (two clk of latency)
// RST_VAL sets the value both flops take in reset.
module spi_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave, oversampling the SPI pins in the clk domain.
//   clk, rst_n       : sole clock, synchronous active-low reset
//   ss, sck, mosi    : asynchronous SPI pins (ss active low)
//   miso             : registered serial data out
//   miso_enable      : ~ss, combinational pad tristate enable
//   bus (slave)      : tx/rx word handshakes and status pulses
// Parameters: WIDTH (4..32), CPOL, CPHA, MSB_FIRST, TX_IDLE.
// Optional feature macro SPI_SLAVE_STATUS_EN: when defined, rx_overrun and
// tx_underrun pulse; otherwise both are tied low and their logic is absent.
//
// state     | meaning
// ST_WAIT   | after reset; waiting to see ss high before accepting frames
// ST_IDLE   | ss high; counter at 0, next transmit word already loaded
// ST_ACTIVE | ss low; sampling mosi and shifting miso on sck edges
module spi_slave_param
  import spi_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter bit               CPOL      = 1'b0,
  parameter bit               CPHA      = 1'b0,
  parameter bit               MSB_FIRST = 1'b1,
  parameter logic [WIDTH-1:0] TX_IDLE   = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ss,
  input  logic             sck,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_enable,
  spi_slave_param_if.slave bus
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

  logic ss_s, sck_s, mosi_s;

  // ss resets low so that a frame already in progress at reset release
  // is ignored until ss is seen high.
  spi_sync #(.RST_VAL(1'b0)) u_ss_sync   (.clk(clk), .rst_n(rst_n), .d(ss),   .q(ss_s));
  spi_sync #(.RST_VAL(CPOL)) u_sck_sync  (.clk(clk), .rst_n(rst_n), .d(sck),  .q(sck_s));
  spi_sync #(.RST_VAL(1'b0)) u_mosi_sync (.clk(clk), .rst_n(rst_n), .d(mosi), .q(mosi_s));

  spi_state_e       state_q, state_d;
  logic             sck_prev_q, sck_prev_d;
  logic             sample_q, sample_d;
  logic             shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             miso_q, miso_d;
  logic             load;
  logic             word_done;

  logic sck_rise, sck_fall, lead_edge, trail_edge;

  assign sck_rise   = sck_s & ~sck_prev_q;
  assign sck_fall   = ~sck_s & sck_prev_q;
  assign lead_edge  = CPOL ? sck_fall : sck_rise;
  assign trail_edge = CPOL ? sck_rise : sck_fall;

  always_comb begin
    state_d     = state_q;
    sck_prev_d  = sck_s;
    // Edge strobes are registered so that actions land one clk after detect.
    sample_d    = CPHA ? trail_edge : lead_edge;
    shift_d     = CPHA ? lead_edge : trail_edge;
    cnt_d       = cnt_q;
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    load        = 1'b0;
    word_done   = 1'b0;

    if (rx_valid_q && bus.rx_ready) rx_valid_d = 1'b0;

    case (state_q)
      ST_WAIT: begin
        if (ss_s) begin
          state_d = ST_IDLE;
          load    = 1'b1;
        end
      end
      ST_IDLE: begin
        cnt_d = '0;
        if (!ss_s) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (ss_s) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          rx_sr_d = '0;
          // At a word boundary the next word is already in the shift
          // register; only an aborted word needs a fresh load.
          if (cnt_q != '0) load = 1'b1;
        end else begin
          if (sample_q) begin
            rx_sr_d = MSB_FIRST ? {rx_sr_q[WIDTH-2:0], mosi_s}
                                : {mosi_s, rx_sr_q[WIDTH-1:1]};
            if (cnt_q == LAST_BIT) begin
              cnt_d     = '0;
              word_done = 1'b1;
              load      = 1'b1;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          // The shift edge that follows a completed word (or precedes the
          // first sample) must leave the freshly loaded first bit on miso.
          if (shift_q && cnt_q != '0) begin
            tx_sr_d = MSB_FIRST ? {tx_sr_q[WIDTH-2:0], 1'b1}
                                : {1'b1, tx_sr_q[WIDTH-1:1]};
          end
        end
      end
      default: state_d = ST_WAIT;
    endcase

    if (load) begin
      if (hold_full_q) begin
        tx_sr_d     = hold_q;
        hold_full_d = 1'b0;
      end else begin
        tx_sr_d = TX_IDLE;
      end
    end

    // Accept only into an empty holding register; if a load coincides, the
    // load has already taken TX_IDLE and this word waits for the next one.
    if (bus.tx_valid && !hold_full_q) begin
      hold_d      = bus.tx_data;
      hold_full_d = 1'b1;
    end

    if (word_done) begin
      rx_data_d  = rx_sr_d;
      rx_valid_d = 1'b1;
    end

    miso_d = MSB_FIRST ? tx_sr_d[WIDTH-1] : tx_sr_d[0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_WAIT;
      sck_prev_q  <= CPOL;
      sample_q    <= 1'b0;
      shift_q     <= 1'b0;
      cnt_q       <= '0;
      rx_sr_q     <= '0;
      tx_sr_q     <= '1;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      miso_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      sck_prev_q  <= sck_prev_d;
      sample_q    <= sample_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      miso_q      <= miso_d;
    end
  end

`ifdef SPI_SLAVE_STATUS_EN
  logic rx_overrun_q, rx_overrun_d;
  logic tx_underrun_q, tx_underrun_d;

  always_comb begin
    rx_overrun_d  = word_done && rx_valid_q && !bus.rx_ready;
    tx_underrun_d = load && !hold_full_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_overrun_q  <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      rx_overrun_q  <= rx_overrun_d;
      tx_underrun_q <= tx_underrun_d;
    end
  end

  assign bus.rx_overrun  = rx_overrun_q;
  assign bus.tx_underrun = tx_underrun_q;
`else
  assign bus.rx_overrun  = 1'b0;
  assign bus.tx_underrun = 1'b0;
`endif

  assign miso         = miso_q;
  assign miso_enable  = ~ss;
  assign bus.tx_ready = ~hold_full_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param: an 8-bit mode-0 MSB-first slave and a 16-bit
// mode-3 LSB-first slave, each driven by a simple bit-banged SPI master.
module tb_spi_slave_param;
  import spi_pkg::*;

  localparam int         H   = MIN_SCK_PHASE + 2;
  localparam logic [1:0] M8  = SPI_MODE0;
  localparam logic [1:0] M16 = SPI_MODE3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] ss_p, sck_p, mosi_p;
  wire  [1:0] miso_p, men_p;

  spi_slave_param_if #(.WIDTH(8))  bus8 ();
  spi_slave_param_if #(.WIDTH(16)) bus16 ();

  spi_slave_param #(.WIDTH(8), .CPOL(M8[1]), .CPHA(M8[0]), .MSB_FIRST(1'b1)) u8 (
    .clk(clk), .rst_n(rst_n), .ss(ss_p[0]), .sck(sck_p[0]), .mosi(mosi_p[0]),
    .miso(miso_p[0]), .miso_enable(men_p[0]), .bus(bus8));

  spi_slave_param #(.WIDTH(16), .CPOL(M16[1]), .CPHA(M16[0]), .MSB_FIRST(1'b0)) u16 (
    .clk(clk), .rst_n(rst_n), .ss(ss_p[1]), .sck(sck_p[1]), .mosi(mosi_p[1]),
    .miso(miso_p[1]), .miso_enable(men_p[1]), .bus(bus16));

  int n_cmp = 0;
  int n_bad = 0;
  int und8 = 0, und16 = 0, ovr8 = 0, ovr16 = 0;

  always @(negedge clk) begin
    if (bus8.tx_underrun === 1'b1)  und8  <= und8 + 1;
    if (bus16.tx_underrun === 1'b1) und16 <= und16 + 1;
    if (bus8.rx_overrun === 1'b1)   ovr8  <= ovr8 + 1;
    if (bus16.rx_overrun === 1'b1)  ovr16 <= ovr16 + 1;
  end

  typedef struct {
    string      name;
    bit         push_en;
    logic [7:0] push_w;
    logic [7:0] mo;
    logic [7:0] exp_mi;
    int         exp_und;
  } vec_t;

  vec_t tbl[5];

  function automatic int stat_exp(input int n);
`ifdef SPI_SLAVE_STATUS_EN
    return n;
`else
    return 0 * n;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] rxd(input int d);
    return (d == 0) ? 32'(bus8.rx_data) : 32'(bus16.rx_data);
  endfunction

  function automatic logic rxv(input int d);
    return (d == 0) ? bus8.rx_valid : bus16.rx_valid;
  endfunction

  task automatic push(input int d, input logic [31:0] data);
    int t = 0;
    while (((d == 0) ? bus8.tx_ready : bus16.tx_ready) !== 1'b1 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL push_timeout: tx_ready got 0 expected 1 on dut %0d", d);
    end else begin
      if (d == 0) begin bus8.tx_data = data[7:0];   bus8.tx_valid = 1'b1;  end
      else        begin bus16.tx_data = data[15:0]; bus16.tx_valid = 1'b1; end
      @(negedge clk);
      bus8.tx_valid  = 1'b0;
      bus16.tx_valid = 1'b0;
    end
  endtask

  task automatic pop(input int d, input string nm);
    if (d == 0) bus8.rx_ready = 1'b1; else bus16.rx_ready = 1'b1;
    @(negedge clk);
    bus8.rx_ready  = 1'b0;
    bus16.rx_ready = 1'b0;
    chk({nm, "_pop_clr"}, 32'(rxv(d)), 32'd0);
  endtask

  task automatic frame_begin(input int d);
    ss_p[d] = 1'b0;
    wait_clk(H);
  endtask

  task automatic frame_end(input int d);
    ss_p[d] = 1'b1;
    wait_clk(H + 2);
  endtask

  task automatic xfer(input int d, input int w, input bit cpol, input bit cpha,
                      input bit msb, input logic [31:0] mo, output logic [31:0] mi);
    mi = '0;
    for (int i = 0; i < w; i++) begin
      int idx;
      idx = msb ? (w - 1 - i) : i;
      if (!cpha) begin
        mosi_p[d] = mo[idx];
        wait_clk(H);
        mi[idx]   = miso_p[d];
        sck_p[d]  = ~cpol;
        wait_clk(H);
        sck_p[d]  = cpol;
      end else begin
        sck_p[d]  = ~cpol;
        mosi_p[d] = mo[idx];
        wait_clk(H);
        mi[idx]   = miso_p[d];
        sck_p[d]  = cpol;
        wait_clk(H);
      end
    end
    wait_clk(H);
  endtask

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: run did not complete within cycle budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] mi, mi_b;
    int          u0, o0;

    tbl[0] = '{"mode0_a5",       1'b0, 8'h00, 8'hA5, 8'h3C, 1};
    tbl[1] = '{"underrun_ff",    1'b0, 8'h00, 8'h5A, 8'hFF, 1};
    tbl[2] = '{"push_into_hold", 1'b1, 8'hC3, 8'h00, 8'hFF, 0};
    tbl[3] = '{"hold_pipeline",  1'b0, 8'h00, 8'hFF, 8'hC3, 1};
    tbl[4] = '{"push_again",     1'b1, 8'h55, 8'h96, 8'hFF, 0};

    rst_n          = 1'b0;
    ss_p           = 2'b11;
    sck_p          = {M16[1], M8[1]};
    mosi_p         = 2'b00;
    bus8.tx_data   = '0;
    bus8.tx_valid  = 1'b0;
    bus8.rx_ready  = 1'b0;
    bus16.tx_data  = '0;
    bus16.tx_valid = 1'b0;
    bus16.rx_ready = 1'b0;
    wait_clk(4);

    chk("rst_miso8",      32'(miso_p[0]),          32'd1);
    chk("rst_miso16",     32'(miso_p[1]),          32'd1);
    chk("rst_tx_ready",   32'(bus8.tx_ready),      32'd1);
    chk("rst_rx_valid",   32'(bus8.rx_valid),      32'd0);
    chk("rst_rx_data",    32'(bus8.rx_data),       32'd0);
    chk("rst_overrun",    32'(bus8.rx_overrun),    32'd0);
    chk("rst_underrun",   32'(bus8.tx_underrun),   32'd0);
    chk("idle_miso_en",   32'(men_p[0]),           32'd0);

    // Preload the holding registers right at reset release.
    bus8.tx_data   = 8'h3C;
    bus8.tx_valid  = 1'b1;
    bus16.tx_data  = 16'h0F0F;
    bus16.tx_valid = 1'b1;
    rst_n          = 1'b1;
    @(negedge clk);
    bus8.tx_valid  = 1'b0;
    bus16.tx_valid = 1'b0;
    wait_clk(4);

    // 16-bit, mode 3, LSB first: two words in one frame, no status pulses.
    push(1, 32'hF0F0);
    frame_begin(1);
    xfer(1, 16, M16[1], M16[0], 1'b0, 32'h1234, mi);
    chk("m3_w1_miso", mi,       32'h0F0F);
    chk("m3_w1_rx",   rxd(1),   32'h1234);
    chk("m3_w1_rxv",  32'(rxv(1)), 32'd1);
    pop(1, "m3_w1");
    push(1, 32'hAAAA);
    xfer(1, 16, M16[1], M16[0], 1'b0, 32'hBEEF, mi);
    frame_end(1);
    chk("m3_w2_miso", mi,       32'hF0F0);
    chk("m3_w2_rx",   rxd(1),   32'hBEEF);
    chk("m3_w2_rxv",  32'(rxv(1)), 32'd1);
    pop(1, "m3_w2");
    chk("m3_underrun", 32'(und16), 32'd0);
    chk("m3_overrun",  32'(ovr16), 32'd0);

    // 8-bit, mode 0, MSB first: single-word frames from the table.
    for (int k = 0; k < 5; k++) begin
      if (tbl[k].push_en) push(0, 32'(tbl[k].push_w));
      u0 = und8;
      frame_begin(0);
      chk({tbl[k].name, "_miso_en"}, 32'(men_p[0]), 32'd1);
      xfer(0, 8, M8[1], M8[0], 1'b1, 32'(tbl[k].mo), mi);
      frame_end(0);
      chk({tbl[k].name, "_miso"}, mi,                32'(tbl[k].exp_mi));
      chk({tbl[k].name, "_rx"},   rxd(0),            32'(tbl[k].mo));
      chk({tbl[k].name, "_rxv"},  32'(rxv(0)),       32'd1);
      chk({tbl[k].name, "_und"},  32'(und8 - u0),    32'(stat_exp(tbl[k].exp_und)));
      pop(0, tbl[k].name);
    end

    // Two words with rx_ready low: second overwrites first.
    u0 = und8;
    o0 = ovr8;
    frame_begin(0);
    xfer(0, 8, M8[1], M8[0], 1'b1, 32'h11, mi);
    xfer(0, 8, M8[1], M8[0], 1'b1, 32'h22, mi_b);
    frame_end(0);
    chk("ovr_miso_w1", mi,            32'h55);
    chk("ovr_miso_w2", mi_b,          32'hFF);
    chk("ovr_rx",      rxd(0),        32'h22);
    chk("ovr_rxv",     32'(rxv(0)),   32'd1);
    chk("ovr_pulses",  32'(ovr8 - o0), 32'(stat_exp(1)));
    chk("ovr_und",     32'(und8 - u0), 32'(stat_exp(2)));
    pop(0, "ovr");

    // ss rises after 5 bits: partial word dropped, held word reloaded.
    push(0, 32'h69);
    u0 = und8;
    frame_begin(0);
    xfer(0, 5, M8[1], M8[0], 1'b1, 32'h1F, mi);
    frame_end(0);
    chk("abort_rxv",       32'(rxv(0)),    32'd0);
    chk("abort_idle_miso", 32'(miso_p[0]), 32'd0);
    frame_begin(0);
    xfer(0, 8, M8[1], M8[0], 1'b1, 32'h81, mi);
    frame_end(0);
    chk("abort_next_miso", mi,             32'h69);
    chk("abort_next_rx",   rxd(0),         32'h81);
    chk("abort_next_rxv",  32'(rxv(0)),    32'd1);
    chk("abort_und",       32'(und8 - u0), 32'(stat_exp(1)));
    pop(0, "abort");

    // Reset mid-frame with ss held low: nothing accepted until ss goes high.
    frame_begin(0);
    xfer(0, 3, M8[1], M8[0], 1'b1, 32'h5, mi);
    rst_n = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(1);
    push(0, 32'h96);
    xfer(0, 8, M8[1], M8[0], 1'b1, 32'hA5, mi);
    wait_clk(4);
    chk("rstmid_rxv",  32'(rxv(0)), 32'd0);
    chk("rstmid_rx",   rxd(0),      32'd0);
    frame_end(0);
    frame_begin(0);
    xfer(0, 8, M8[1], M8[0], 1'b1, 32'h7E, mi);
    frame_end(0);
    chk("rstmid_next_miso", mi,          32'h96);
    chk("rstmid_next_rx",   rxd(0),      32'h7E);
    chk("rstmid_next_rxv",  32'(rxv(0)), 32'd1);
    pop(0, "rstmid");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
